// File: rtl/irq_nmi_arbiter_if.sv
// Bundle between the 6502 core and irq_nmi_arbiter: request lines,
// instruction-boundary/ack strobes, and the held request back to the core.
interface irq_nmi_arbiter_if #(
    parameter int N_IRQ = 4,
    parameter int SRC_W = 2
);
    logic             nmi_n;
    logic [N_IRQ-1:0] irq_n;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] irq_en;
    logic             cpu_i;
    logic             inst_done;
    logic             ack;
    logic [N_IRQ-1:0] clr;
    logic             int_req;
    logic             int_nmi;
    logic [SRC_W-1:0] int_src;
    logic [7:0]       vec_lo;
    logic [N_IRQ-1:0] pending;
    logic             nmi_pend;

    modport slave (
        input  nmi_n, irq_n, irq_edge, irq_en, cpu_i, inst_done, ack, clr,
        output int_req, int_nmi, int_src, vec_lo, pending, nmi_pend
    );
    modport master (
        output nmi_n, irq_n, irq_edge, irq_en, cpu_i, inst_done, ack, clr,
        input  int_req, int_nmi, int_src, vec_lo, pending, nmi_pend
    );
endinterface

// File: rtl/irq_nmi_arbiter.sv
// NMI + N_IRQ interrupt arbiter for the 6502 core; arbitrates on inst_done.
// Optional IRQ_NMI_HIJACK_EN: a late NMI replaces a held, unacked IRQ.
module irq_nmi_arbiter #(
    parameter int N_IRQ = 4,
    parameter int SRC_W = 2
) (
    input logic              clk_ph1,
    input logic              rst,
    irq_nmi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    state_t           state, state_nxt;
    logic [N_IRQ:0]   s1, s2, hist, fall;
    logic [N_IRQ-1:0] pend, pend_d;
    logic             nmi_p, nmi_p_d;
    logic             int_req, int_nmi;
    logic [SRC_W-1:0] int_src;
    logic [7:0]       vec_lo;
    logic             cand_vld, cand_nmi;
    logic [SRC_W-1:0] cand_src;
    logic             capture, ack_fire, hijack;

    // Bit N_IRQ carries NMI so every line shares one synchroniser.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            s1   <= '1;
            s2   <= '1;
            hist <= '1;
        end else begin
            s1   <= {bus.nmi_n, bus.irq_n};
            s2   <= s1;
            hist <= s2;
        end
    end

    assign fall = hist & ~s2;

    // Clears are applied first so a coincident edge wins.
    always_comb begin
        pend_d  = pend;
        nmi_p_d = nmi_p;
        if (ack_fire && int_nmi) nmi_p_d = 1'b0;
        if (fall[N_IRQ])         nmi_p_d = 1'b1;
        for (int i = 0; i < N_IRQ; i++) begin
            if (bus.irq_edge[i]) begin
                if (bus.clr[i] || (ack_fire && !int_nmi && int_src == SRC_W'(i)))
                    pend_d[i] = 1'b0;
                if (fall[i])
                    pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = ~s2[i];
            end
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            pend  <= '0;
            nmi_p <= 1'b0;
        end else begin
            pend  <= pend_d;
            nmi_p <= nmi_p_d;
        end
    end

    // Lowest enabled IRQ index wins; NMI overrides all.
    always_comb begin
        cand_vld = 1'b0;
        cand_nmi = 1'b0;
        cand_src = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i] && bus.irq_en[i] && !bus.cpu_i) begin
                cand_vld = 1'b1;
                cand_src = SRC_W'(i);
            end
        end
        if (nmi_p) begin
            cand_vld = 1'b1;
            cand_nmi = 1'b1;
            cand_src = '0;
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack_fire  = 1'b0;
        hijack    = 1'b0;
        case (state)
            IDLE: if (bus.inst_done && cand_vld) begin
                state_nxt = REQ;
                capture   = 1'b1;
            end
            REQ: begin
                if (bus.ack) begin
                    state_nxt = SVC;
                    ack_fire  = 1'b1;
                end
`ifdef IRQ_NMI_HIJACK_EN
                // The vector fetch in progress takes precedence over a late NMI.
                else if (!int_nmi && nmi_p) begin
                    hijack = 1'b1;
                end
`endif
            end
            SVC: if (bus.inst_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            int_req <= 1'b0;
            int_nmi <= 1'b0;
            int_src <= '0;
            vec_lo  <= VEC_IRQ;
        end else if (capture) begin
            int_req <= 1'b1;
            int_nmi <= cand_nmi;
            int_src <= cand_src;
            vec_lo  <= cand_nmi ? VEC_NMI : VEC_IRQ;
        end else if (hijack) begin
            int_nmi <= 1'b1;
            int_src <= '0;
            vec_lo  <= VEC_NMI;
        end else if (ack_fire) begin
            int_req <= 1'b0;
        end
    end

    assign bus.int_req  = int_req;
    assign bus.int_nmi  = int_nmi;
    assign bus.int_src  = int_src;
    assign bus.vec_lo   = vec_lo;
    assign bus.pending  = pend;
    assign bus.nmi_pend = nmi_p;
endmodule

// File: tb/tb_irq_nmi_arbiter.sv
// Scoreboard bench for irq_nmi_arbiter: expected requests are queued when
// inst_done is driven and checked when int_req rises.
module tb_irq_nmi_arbiter;
    logic clk_ph1 = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        logic       nmi;
        logic [1:0] src;
        logic [7:0] vec;
    } req_t;
    req_t sb[$];

    irq_nmi_arbiter_if #(.N_IRQ(4), .SRC_W(2)) bus();
    irq_nmi_arbiter #(.N_IRQ(4), .SRC_W(2)) dut (.clk_ph1(clk_ph1), .rst(rst), .bus(bus));

    always #5 clk_ph1 = ~clk_ph1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_ph1);
        #1;
    endtask

    task automatic pulse_done();
        bus.inst_done = 1'b1; tick(); bus.inst_done = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    endtask

    task automatic expect_req(input logic nmi, input logic [1:0] src);
        req_t r;
        r.nmi = nmi; r.src = src; r.vec = nmi ? 8'hFA : 8'hFE;
        sb.push_back(r);
    endtask

    // Scoreboard side: every new request must match the oldest expectation.
    logic req_prev = 1'b0;
    always @(negedge clk_ph1) begin
        if (bus.int_req && !req_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                req_t r;
                r = sb.pop_front();
                chk("sb_nmi", bus.int_nmi, r.nmi);
                chk("sb_src", bus.int_src, r.src);
                chk("sb_vec", bus.vec_lo, r.vec);
            end
        end
        req_prev = bus.int_req;
    end

    initial begin
        rst = 1'b0;
        bus.nmi_n = 1'b1; bus.irq_n = 4'hF; bus.irq_edge = 4'hF; bus.irq_en = 4'hF;
        bus.cpu_i = 1'b0; bus.inst_done = 1'b0; bus.ack = 1'b0; bus.clr = 4'h0;
        tick(2);
        chk("rst_req", bus.int_req, 0);
        chk("rst_nmi", bus.int_nmi, 0);
        chk("rst_src", bus.int_src, 0);
        chk("rst_vec", bus.vec_lo, 8'hFE);
        chk("rst_pend", bus.pending, 0);
        chk("rst_npend", bus.nmi_pend, 0);
        rst = 1'b1;
        tick(3);
        chk("no_false_edge", bus.pending, 0);

        // Edge latency: pending two edges after the fall is sampled
        bus.irq_n[2] = 1'b0;
        tick(2);
        chk("lat_k1", bus.pending, 4'b0000);
        tick();
        chk("lat_k2", bus.pending, 4'b0100);
        expect_req(0, 2);
        pulse_done();
        chk("lat_req", bus.int_req, 1);
        pulse_ack();
        chk("lat_ack_req", bus.int_req, 0);
        chk("lat_ack_pend", bus.pending, 0);
        bus.irq_n[2] = 1'b1;
        pulse_done();
        chk("lat_svc_exit", bus.int_req, 0);

        // Priority: NMI before simultaneous IRQ0
        bus.nmi_n = 1'b0; bus.irq_n[0] = 1'b0;
        tick(3);
        chk("pri_npend", bus.nmi_pend, 1);
        expect_req(1, 0);
        pulse_done();
        chk("pri_nmi", bus.int_nmi, 1);
        chk("pri_vec", bus.vec_lo, 8'hFA);
        pulse_ack();
        chk("pri_npend_clr", bus.nmi_pend, 0);
        chk("pri_irq0_kept", bus.pending, 4'b0001);
        pulse_done();
        chk("pri_svc_noreq", bus.int_req, 0);
        expect_req(0, 0);
        pulse_done();
        chk("pri_irq0_req", bus.int_req, 1);
        pulse_ack();
        pulse_done();
        bus.nmi_n = 1'b1; bus.irq_n[0] = 1'b1;
        tick(3);

        // Masking by cpu_i; NMI still passes
        bus.cpu_i = 1'b1;
        bus.irq_n = 4'h0;
        tick(3);
        chk("msk_pend", bus.pending, 4'hF);
        for (int i = 0; i < 5; i++) begin
            pulse_done();
            chk("msk_noreq", bus.int_req, 0);
        end
        bus.nmi_n = 1'b0;
        tick(3);
        expect_req(1, 0);
        pulse_done();
        chk("msk_nmi_req", bus.int_req, 1);
        chk("msk_nmi", bus.int_nmi, 1);
        pulse_ack();
        pulse_done();
        bus.clr = 4'hF; tick(); bus.clr = 4'h0;
        chk("msk_clr", bus.pending, 0);
        bus.irq_n = 4'hF; bus.nmi_n = 1'b1; bus.cpu_i = 1'b0;
        tick(3);

        // Level mode: ack does not clear; release clears two edges later
        bus.irq_edge[1] = 1'b0;
        bus.irq_n[1] = 1'b0;
        tick(3);
        chk("lvl_pend", bus.pending, 4'b0010);
        expect_req(0, 1);
        pulse_done();
        chk("lvl_src", bus.int_src, 1);
        pulse_ack();
        chk("lvl_after_ack", bus.pending[1], 1);
        pulse_done();
        bus.irq_n[1] = 1'b1;
        tick(2);
        chk("lvl_rel_r1", bus.pending[1], 1);
        tick();
        chk("lvl_rel_r2", bus.pending[1], 0);
        bus.irq_edge[1] = 1'b1;

        // Clear collision, ignored ack in IDLE, plain clear
        bus.irq_n[3] = 1'b0;
        tick(2);
        bus.clr[3] = 1'b1; tick(); bus.clr[3] = 1'b0;
        chk("coll_set_wins", bus.pending[3], 1);
        pulse_ack();
        chk("idle_ack_ign", bus.pending[3], 1);
        chk("idle_ack_req", bus.int_req, 0);
        bus.clr[3] = 1'b1; tick(); bus.clr[3] = 1'b0;
        chk("clr3", bus.pending, 0);
        bus.irq_n[3] = 1'b1;
        tick(3);

        // NMI arriving while IRQ1 is held
        bus.irq_n[1] = 1'b0;
        tick(3);
        expect_req(0, 1);
        pulse_done();
        chk("hj_src", bus.int_src, 1);
        bus.nmi_n = 1'b0;
        tick(4);
`ifdef IRQ_NMI_HIJACK_EN
        chk("hj_nmi", bus.int_nmi, 1);
        chk("hj_vec", bus.vec_lo, 8'hFA);
        chk("hj_src0", bus.int_src, 0);
        pulse_ack();
        chk("hj_irq1_kept", bus.pending[1], 1);
        chk("hj_npend_clr", bus.nmi_pend, 0);
        pulse_done();
        expect_req(0, 1);
        pulse_done();
        pulse_ack();
        pulse_done();
`else
        chk("hold_nmi", bus.int_nmi, 0);
        chk("hold_vec", bus.vec_lo, 8'hFE);
        pulse_ack();
        chk("hold_irq1_clr", bus.pending[1], 0);
        chk("hold_npend", bus.nmi_pend, 1);
        pulse_done();
        expect_req(1, 0);
        pulse_done();
        chk("hold_nmi_req", bus.int_nmi, 1);
        pulse_ack();
        pulse_done();
`endif
        bus.irq_n[1] = 1'b1; bus.nmi_n = 1'b1;
        tick(3);

        // Reset in REQ discards the request
        bus.irq_n[0] = 1'b0;
        tick(3);
        expect_req(0, 0);
        pulse_done();
        chk("mid_req", bus.int_req, 1);
        bus.irq_n[0] = 1'b1;
        rst = 1'b0;
        tick();
        chk("mid_rst_req", bus.int_req, 0);
        chk("mid_rst_pend", bus.pending, 0);
        chk("mid_rst_vec", bus.vec_lo, 8'hFE);
        rst = 1'b1;
        tick(3);
        pulse_done();
        chk("mid_idle", bus.int_req, 0);

        tick(2);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/irq_nmi_arbiter.md
# irq_nmi_arbiter

Parametrised interrupt arbiter that replaces the fixed two-input IRQ/NMI detector beside the 6502 core. It accepts one NMI line and `N_IRQ` maskable IRQ sources, each independently edge- or level-sensitive. It synchronises and latches requests, arbitrates them at instruction boundaries, and presents one held request with its vector low byte to the CPU's instruction decoder. It clears the serviced source when the CPU acknowledges the vector fetch.

## Interface
- `N_IRQ`, default 4: number of maskable IRQ sources, 1..16.
- `SRC_W`, default 2: width of `int_src`; must equal max(1, clog2(`N_IRQ`)).
- `clk_ph1` in 1: clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `nmi_n` in 1: NMI request, active-low, falling-edge sensitive.
- `irq_n` in `N_IRQ`: IRQ requests, active-low.
- `irq_edge` in `N_IRQ`: per-source mode; 1 = falling-edge latched, 0 = level.
- `irq_en` in `N_IRQ`: per-source enable mask; 1 = enabled.
- `cpu_i` in 1: CPU status I flag (P[2]); 1 blocks all IRQs, never NMI.
- `inst_done` in 1: one-cycle pulse on the CPU's last cycle of an instruction.
- `ack` in 1: one-cycle pulse on the CPU's vector-fetch cycle.
- `clr` in `N_IRQ`: write-1-to-clear for edge-mode pending bits.
- `int_req` out 1: request to the CPU, registered.
- `int_nmi` out 1: the held request is NMI.
- `int_src` out `SRC_W`: index of the held IRQ source; 0 when `int_nmi`.
- `vec_lo` out 8: 8'hFA for NMI, 8'hFE for IRQ.
- `pending` out `N_IRQ`: registered pending bits.
- `nmi_pend` out 1: registered NMI pending bit.

## Operation
- **Synchroniser.** `nmi_n` and every `irq_n` bit pass through two flops, then a history flop. All three stages reset to 1, so no false edge occurs out of reset.
- **NMI pending.** `nmi_pend` is set on a synchronised falling edge. It is cleared on `ack` when the held request is NMI.
- **Edge-mode pending.** `pending[i]` is set on a synchronised falling edge. It is cleared by `clr[i]` or by `ack` when `i` is the held IRQ source.
- **Level-mode pending.** `pending[i]` equals the inverted synchronised level. `clr` and `ack` have no effect.
- **Candidate selection.** NMI is the candidate if `nmi_pend` is set. Otherwise the lowest index `i` with `pending[i] & irq_en[i] & ~cpu_i` is the candidate.
- **State machine** (states IDLE, REQ, SVC):
  - IDLE → REQ on `inst_done` with a valid candidate. The candidate is captured into `int_nmi`, `int_src` and `vec_lo`, and `int_req` is set to 1.
  - REQ → SVC on `ack`. `int_req` goes to 0 and the held source is cleared as above.
  - SVC → IDLE on the next `inst_done`. That pulse does not arbitrate, so one request cannot be taken twice.
- **Captured outputs stay stable in REQ.** A level source deasserting, a mask change or a `cpu_i` change does not withdraw the request.
- **Ignored acks.** `ack` in IDLE or SVC is ignored.
- **Set beats clear.** A new edge in the same cycle as `clr`/`ack` clearing that bit leaves the bit set.

## Timing
- **Reset values** (on the edge with `rst`=0): `int_req`=0, `int_nmi`=0, `int_src`=0, `vec_lo`=8'hFE, `pending`=0, `nmi_pend`=0, state IDLE.
- **Input to pending.** An input falling before edge k gives `pending`/`nmi_pend` high after edge k+2.
- **Arbitration.** Pending visible before edge m with `inst_done` at edge m gives `int_req`=1 after edge m.
- **Acknowledge.** `ack` at edge a gives `int_req`=0 and the pending bit cleared after edge a.
- **Reset mid-operation.** Reset in any state forces the reset values on that edge. In-flight requests are discarded.

## Configuration
- **`IRQ_NMI_HIJACK_EN` defined.** In REQ with `int_nmi`=0, a rising `nmi_pend` switches the held request on the next edge: `int_nmi`=1, `int_src`=0, `vec_lo`=8'hFA. The subsequent `ack` clears only NMI; the IRQ pending bit is retained.
- **Macro undefined.** The captured request is fixed until `ack`. NMI waits for the next arbitration.

## Test plan
- **Edge latency.** Reset, then `irq_n[2]` falls before edge 10 in edge mode → `pending`=4'b0100 after edge 12. `inst_done` at edge 13 → `int_req`=1, `int_src`=2, `vec_lo`=8'hFE.
- **Priority.** `nmi_n` and `irq_n[0]` fall together → `int_nmi`=1, `vec_lo`=8'hFA. After `ack`, `nmi_pend`=0 and `pending[0]`=1. At the SVC-exiting `inst_done`, no request; at the following `inst_done`, `int_src`=0.
- **Masking.** `cpu_i`=1 and `irq_en`=4'b1111 with all IRQs pending → no `int_req` across 5 `inst_done` pulses. NMI edge → `int_req`=1, `int_nmi`=1.
- **Level mode.** `irq_edge[1]`=0, hold `irq_n[1]` low, then `ack` → `pending[1]` stays 1. Release → `pending[1]`=0 two edges after the release is sampled.
- **Clear collision.** `clr[3]`=1 on the same edge a new synchronised edge on source 3 is detected → `pending[3]`=1.
- **Hijack (`IRQ_NMI_HIJACK_EN` defined).** While in REQ with `int_src`=1, inject an NMI → next edge `vec_lo`=8'hFA. `ack` → `pending[1]` still 1.
